pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control unit in the multicycle MIPS datapath. Holds the program counter and issues instruction-memory reads. It latches the returned word onto imemload for the control unit. It computes the next PC from the control unit's PCsel/halt outputs and the branch decision, and freezes fetch permanently once halt is seen.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
ihit  input  1  instruction memory has returned iload this cycle.
iload  input  32  instruction word from instruction memory.
ex_done  input  1  datapath finished the current instruction; PC may advance.
PCsel  input  2  next-PC select from control unit: 00 PC+4, 01 branch, 10 jump, 11 jump-register.
br_take  input  1  branch condition true (from ALU zero flag logic).
rdat1  input  32  register rs value for jump-register.
halt  input  1  halt decoded by control unit.
iREN  output  1  instruction memory read enable.
iaddr  output  32  instruction address (equals pc).
imemload  output  32  latched instruction, feeds control unit.
instr_valid  output  1  one-cycle pulse when imemload is newly loaded.
pc  output  32  current PC.
npc  output  32  pc+4, used as the JAL link value.
halted  output  1  sticky, core has stopped.

Behaviour:
- Reset (async, RST=1): pc=PC_INIT; imemload=32'h0 (NOP); instr_valid=0; halted=0; state=FETCH; iREN=0 while RST is high.
- FSM states: FETCH, EXEC, HALTED.
- FETCH:
  - iREN=1, iaddr=pc.
  - On ihit: imemload<=iload, instr_valid<=1 for the next cycle only, go to EXEC.
  - Without ihit: hold all state.
- EXEC:
  - iREN=0; ihit is ignored.
  - If halt=1: go to HALTED; pc holds (stays at the halt instruction's address) regardless of ex_done.
  - Else if ex_done=1: pc<=next_pc, go to FETCH.
  - Else: hold.
- HALTED:
  - iREN=0, halted=1; absorbing state until reset.
  - ihit, ex_done and PCsel are ignored.
- next_pc, with PC4 = pc+4 and 32-bit wrap (32'hFFFF_FFFC+4 = 0):
  - 00: PC4.
  - 01: br_take ? PC4 + (sext(imem[15:0])<<2) : PC4.
  - 10: {PC4[31:28], imem[25:0], 2'b00}.
  - 11: {rdat1[31:2], 2'b00}; low bits are forced to zero.
  - imem above means the latched imemload.
- Minimum latency: fetch to PC update is 2 cycles (ihit in the first FETCH cycle, ex_done in the first EXEC cycle).
- npc = pc+4 combinationally, always valid.
- imemload is stable from entry to EXEC until the next ihit in FETCH.
- RST asserted mid-operation (any state) forces the reset values immediately. The first FETCH starts in the cycle after RST deasserts.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined: adds outputs instr_count[31:0] and fetch_stall_count[31:0].
  - instr_count increments on each EXEC→FETCH transition.
  - fetch_stall_count increments each FETCH cycle with ihit=0.
  - Both reset to 0, wrap at 2^32, and freeze in HALTED.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_types_pkg:
  - word_t (32-bit).
  - pcsel_t enum: PC_NEXT=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11.
  - fetch_state_t enum: FETCH, EXEC, HALTED.
  - Constant WORD_BYTES=4.
- Sub-module pc_next_calc (purely combinational): inputs pc, imemload, PCsel, br_take, rdat1; outputs next_pc and npc.
- pc_fetch_unit keeps the FSM and registers.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: PC_INIT=0; ihit=1 in the first FETCH cycle, iload=32'h2001_0005; ex_done=1 in EXEC, PCsel=00.
  - Required: imemload=32'h2001_0005; instr_valid pulses once; pc=4 after 2 cycles; iaddr=4 with iREN=1.
- Memory wait:
  - Stimulus: ihit low for 3 cycles in FETCH.
  - Required: iREN=1 and pc constant throughout; imemload unchanged; EXEC entered the cycle after ihit (with FETCH_PERF_CNT_EN: fetch_stall_count=3).
- Branch, PC=32'h10, imemload imm16=16'hFFFE, PCsel=01:
  - br_take=1 → pc=32'h0C.
  - br_take=0 → pc=32'h14.
- Jump and JR:
  - Stimulus: pc=32'h1000_0000, J imm26=26'h000_0040 → pc=32'h1000_0100.
  - Stimulus: PCsel=11 with rdat1=32'h0000_0207 → pc=32'h0000_0204.
- Halt with simultaneous ex_done:
  - Stimulus: halt=1 and ex_done=1 in EXEC at pc=32'h20.
  - Required: halted=1; pc stays 32'h20; iREN=0 forever despite later ihit.
- Reset mid-EXEC:
  - Stimulus: RST pulsed during EXEC at pc=32'h40.
  - Required: pc=PC_INIT, imemload=0 and halted=0 immediately; fetch resumes at PC_INIT after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: word type, next-PC select encoding,
// fetch FSM states and the instruction word size.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PC_NEXT = 2'b00,
        PC_BR   = 2'b01,
        PC_J    = 2'b10,
        PC_JR   = 2'b11
    } pcsel_t;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        EXEC   = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, branch, jump and jump-register
// targets, plus pc+4 for the link value. All arithmetic wraps at 32 bits.
module pc_next_calc
    import cpu_types_pkg::*;
(
    input  word_t  pc,
    input  word_t  imemload,
    input  pcsel_t PCsel,
    input  logic   br_take,
    input  word_t  rdat1,
    output word_t  next_pc,
    output word_t  npc
);

    word_t pc4;
    word_t br_off;
    logic  unused_bits;

    assign pc4    = pc + WORD_BYTES;
    assign npc    = pc4;
    // Sign-extended imm16 already scaled to a byte offset.
    assign br_off = {{14{imemload[15]}}, imemload[15:0], 2'b00};

    assign unused_bits = ^{imemload[31:26], rdat1[1:0]};

    always_comb begin
        next_pc = pc4;
        unique case (PCsel)
            PC_NEXT: next_pc = pc4;
            PC_BR:   next_pc = br_take ? (pc4 + br_off) : pc4;
            PC_J:    next_pc = {pc4[31:28], imemload[25:0], 2'b00};
            PC_JR:   next_pc = {rdat1[31:2], 2'b00};
            default: next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage FSM: holds the PC, reads instruction memory, latches the word
// for the control unit and stops permanently on halt.
// Optional macro FETCH_PERF_CNT_EN adds instruction and fetch-stall counters.
module pc_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        ex_done,
    input  logic [1:0]  PCsel,
    input  logic        br_take,
    input  logic [31:0] rdat1,
    input  logic        halt,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] imemload,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] fetch_stall_count
`endif
);

    fetch_state_t state;
    word_t        next_pc;

    pc_next_calc u_next (
        .pc       (pc),
        .imemload (imemload),
        .PCsel    (pcsel_t'(PCsel)),
        .br_take  (br_take),
        .rdat1    (rdat1),
        .next_pc  (next_pc),
        .npc      (npc)
    );

    // Read enable is masked by reset so memory sees no request while held.
    assign iREN  = (state == FETCH) && !RST;
    assign iaddr = pc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            imemload    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (ihit) begin
                        imemload    <= iload;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // Halt wins over ex_done so pc stays on the halt instruction.
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (ex_done) begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_count       <= '0;
            fetch_stall_count <= '0;
        end else begin
            if (state == EXEC && !halt && ex_done)
                instr_count <= instr_count + 32'd1;
            if (state == FETCH && !ihit)
                fetch_stall_count <= fetch_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; inputs change and outputs are
// sampled on the falling edge.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] iload;
    logic        ex_done;
    logic [1:0]  PCsel;
    logic        br_take;
    logic [31:0] rdat1;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] imemload;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_count;
    logic [31:0] fetch_stall_count;
`endif

    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .iload       (iload),
        .ex_done     (ex_done),
        .PCsel       (PCsel),
        .br_take     (br_take),
        .rdat1       (rdat1),
        .halt        (halt),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .imemload    (imemload),
        .instr_valid (instr_valid),
        .pc          (pc),
        .npc         (npc),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .instr_count       (instr_count),
        .fetch_stall_count (fetch_stall_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stimulus only: one fetch with immediate ihit, then one EXEC cycle with ex_done.
    task automatic fetch_exec(input logic [31:0] instr, input logic [1:0] sel,
                              input logic br, input logic [31:0] rs);
        ihit  = 1'b1;
        iload = instr;
        @(negedge CLK);
        ihit    = 1'b0;
        ex_done = 1'b1;
        PCsel   = sel;
        br_take = br;
        rdat1   = rs;
        @(negedge CLK);
        ex_done = 1'b0;
        PCsel   = 2'b00;
        br_take = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (imemload !== 32'h0) begin bad++; $display("FAIL reset_imem got=%h exp=%h", imemload, 32'h0); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL reset_iren got=%b exp=0", iREN); end
        ihit  = 1'b1;
        iload = 32'hFFFF_FFFF;
        @(negedge CLK);
        total++; if (imemload !== 32'h0) begin bad++; $display("FAIL reset_hold_imem got=%h exp=%h", imemload, 32'h0); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%b exp=0", instr_valid); end
        ihit = 1'b0;
        RST  = 1'b0;
        #1;
        total++; if (iREN !== 1'b1) begin bad++; $display("FAIL release_iren got=%b exp=1", iREN); end
        total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL release_iaddr got=%h exp=%h", iaddr, 32'h0); end
        total++; if (npc !== 32'h4) begin bad++; $display("FAIL release_npc got=%h exp=%h", npc, 32'h4); end
    endtask

    task automatic test_sequential;
        ihit  = 1'b1;
        iload = 32'h2001_0005;
        @(negedge CLK);
        ihit = 1'b0;
        total++; if (imemload !== 32'h2001_0005) begin bad++; $display("FAIL seq_imem got=%h exp=%h", imemload, 32'h2001_0005); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b exp=1", instr_valid); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL seq_exec_iren got=%b exp=0", iREN); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL seq_pc_exec got=%h exp=%h", pc, 32'h0); end
        ex_done = 1'b1;
        PCsel   = 2'b00;
        @(negedge CLK);
        ex_done = 1'b0;
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'h4); end
        total++; if (iaddr !== 32'h4) begin bad++; $display("FAIL seq_iaddr got=%h exp=%h", iaddr, 32'h4); end
        total++; if (iREN !== 1'b1) begin bad++; $display("FAIL seq_iren got=%b exp=1", iREN); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_valid_once got=%b exp=0", instr_valid); end
        total++; if (npc !== 32'h8) begin bad++; $display("FAIL seq_npc got=%h exp=%h", npc, 32'h8); end
    endtask

    task automatic test_mem_wait;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++; if (iREN !== 1'b1) begin bad++; $display("FAIL wait_iren[%0d] got=%b exp=1", i, iREN); end
            total++; if (pc !== 32'h4) begin bad++; $display("FAIL wait_pc[%0d] got=%h exp=%h", i, pc, 32'h4); end
            total++; if (imemload !== 32'h2001_0005) begin bad++; $display("FAIL wait_imem[%0d] got=%h exp=%h", i, imemload, 32'h2001_0005); end
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL wait_valid[%0d] got=%b exp=0", i, instr_valid); end
        end
        ihit  = 1'b1;
        iload = 32'h0300_0008;
        @(negedge CLK);
        ihit = 1'b0;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL wait_exec_valid got=%b exp=1", instr_valid); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL wait_exec_iren got=%b exp=0", iREN); end
        total++; if (imemload !== 32'h0300_0008) begin bad++; $display("FAIL wait_exec_imem got=%h exp=%h", imemload, 32'h0300_0008); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (fetch_stall_count !== 32'd3) begin bad++; $display("FAIL stall_count got=%0d exp=3", fetch_stall_count); end
`endif
        // Hold EXEC one cycle without ex_done: pc must not move.
        @(negedge CLK);
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL exec_hold_pc got=%h exp=%h", pc, 32'h4); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL exec_hold_iren got=%b exp=0", iREN); end
        ex_done = 1'b1;
        PCsel   = 2'b11;
        rdat1   = 32'h0000_0010;
        @(negedge CLK);
        ex_done = 1'b0;
        PCsel   = 2'b00;
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL wait_jr_pc got=%h exp=%h", pc, 32'h10); end
    endtask

    task automatic test_branch;
        fetch_exec(32'h1000_FFFE, 2'b01, 1'b1, 32'h0);
        total++; if (pc !== 32'h0C) begin bad++; $display("FAIL br_taken got=%h exp=%h", pc, 32'h0C); end
        fetch_exec(32'h0, 2'b11, 1'b0, 32'h10);
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL br_setup got=%h exp=%h", pc, 32'h10); end
        fetch_exec(32'h1000_FFFE, 2'b01, 1'b0, 32'h0);
        total++; if (pc !== 32'h14) begin bad++; $display("FAIL br_not_taken got=%h exp=%h", pc, 32'h14); end
    endtask

    task automatic test_jump;
        fetch_exec(32'h0, 2'b11, 1'b0, 32'h1000_0000);
        total++; if (pc !== 32'h1000_0000) begin bad++; $display("FAIL j_setup got=%h exp=%h", pc, 32'h1000_0000); end
        fetch_exec(32'h0800_0040, 2'b10, 1'b0, 32'h0);
        total++; if (pc !== 32'h1000_0100) begin bad++; $display("FAIL j_target got=%h exp=%h", pc, 32'h1000_0100); end
        fetch_exec(32'h0, 2'b11, 1'b0, 32'h0000_0207);
        total++; if (pc !== 32'h0000_0204) begin bad++; $display("FAIL jr_target got=%h exp=%h", pc, 32'h0000_0204); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (instr_count !== 32'd8) begin bad++; $display("FAIL instr_count got=%0d exp=8", instr_count); end
`endif
    endtask

    task automatic test_wrap;
        fetch_exec(32'h0, 2'b11, 1'b0, 32'hFFFF_FFFF);
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'hFFFF_FFFC); end
        total++; if (npc !== 32'h0) begin bad++; $display("FAIL wrap_npc got=%h exp=%h", npc, 32'h0); end
        fetch_exec(32'h0, 2'b00, 1'b0, 32'h0);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_seq got=%h exp=%h", pc, 32'h0); end
    endtask

    task automatic test_halt;
        fetch_exec(32'h0, 2'b11, 1'b0, 32'h20);
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL halt_setup got=%h exp=%h", pc, 32'h20); end
        ihit  = 1'b1;
        iload = 32'hFC00_0000;
        @(negedge CLK);
        ihit    = 1'b0;
        halt    = 1'b1;
        ex_done = 1'b1;
        @(negedge CLK);
        halt = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL halt_pc got=%h exp=%h", pc, 32'h20); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL halt_iren got=%b exp=0", iREN); end
        ihit  = 1'b1;
        PCsel = 2'b11;
        rdat1 = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++; if (iREN !== 1'b0) begin bad++; $display("FAIL halted_iren[%0d] got=%b exp=0", i, iREN); end
            total++; if (pc !== 32'h20) begin bad++; $display("FAIL halted_pc[%0d] got=%h exp=%h", i, pc, 32'h20); end
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted_sticky[%0d] got=%b exp=1", i, halted); end
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halted_valid[%0d] got=%b exp=0", i, instr_valid); end
            total++; if (imemload !== 32'hFC00_0000) begin bad++; $display("FAIL halted_imem[%0d] got=%h exp=%h", i, imemload, 32'hFC00_0000); end
        end
        ihit    = 1'b0;
        ex_done = 1'b0;
        PCsel   = 2'b00;
    endtask

    task automatic test_reset_mid_exec;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL unhalt got=%b exp=0", halted); end
        fetch_exec(32'h0, 2'b11, 1'b0, 32'h40);
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL mid_setup got=%h exp=%h", pc, 32'h40); end
        ihit  = 1'b1;
        iload = 32'hDEAD_BEEF;
        @(negedge CLK);
        ihit = 1'b0;
        total++; if (imemload !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_imem_pre got=%h exp=%h", imemload, 32'hDEAD_BEEF); end
        #2;
        RST = 1'b1;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL mid_rst_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (imemload !== 32'h0) begin bad++; $display("FAIL mid_rst_imem got=%h exp=%h", imemload, 32'h0); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL mid_rst_halted got=%b exp=0", halted); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", instr_valid); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL mid_rst_iren got=%b exp=0", iREN); end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++; if (iREN !== 1'b1) begin bad++; $display("FAIL mid_resume_iren got=%b exp=1", iREN); end
        total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL mid_resume_iaddr got=%h exp=%h", iaddr, 32'h0); end
        fetch_exec(32'h2001_0005, 2'b00, 1'b0, 32'h0);
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL mid_resume_pc got=%h exp=%h", pc, 32'h4); end
    endtask

    initial begin
        RST     = 1'b1;
        ihit    = 1'b0;
        iload   = '0;
        ex_done = 1'b0;
        PCsel   = 2'b00;
        br_take = 1'b0;
        rdat1   = '0;
        halt    = 1'b0;
        @(negedge CLK);
        test_reset;
        test_sequential;
        test_mem_wait;
        test_branch;
        test_jump;
        test_wrap;
        test_halt;
        test_reset_mid_exec;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
